chaos_seq_arbiter: RTL

Shares one logistic_seq chaotic-sequence engine among NUM_REQ requesters, each of which supplies a seed x0.
- Round-robin arbitration; one request in flight at a time.
- Sanitizes degenerate seeds before forwarding them.
- Forwards the granted seed to the engine, captures the engine's CHAOS_OVLD_W-bit output, and returns it only to the requester that was granted.
- Sits between the key-generation clients and the single engine instance.

---
 rtl/chaos_pkg.sv | 29 ++
 rtl/chaos_rr_pick.sv | 30 +++
 rtl/chaos_seq_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/chaos_pkg.sv
// rtl/chaos_pkg.sv - shared types, defaults and seed sanitizer for the chaos sequence arbiter
package chaos_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} arb_state_e;

  localparam int GAIN_INDEX_DEF   = 16;
  localparam int CHAOS_OVLD_W_DEF = 32;
  localparam int SEED_MAX_W       = 32;

  localparam logic [15:0]           DEFAULT_SEED_DEF = 16'h1357;
  localparam logic [SEED_MAX_W-1:0] DEGEN_ZERO       = '0;

  // Seeds are handled at SEED_MAX_W so one function serves any GAIN_INDEX up to 32.
  function automatic logic [SEED_MAX_W-1:0] degen_msb(input int unsigned w);
    return SEED_MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic is_degen_seed(input logic [SEED_MAX_W-1:0] seed,
                                         input int unsigned w);
    return (seed == DEGEN_ZERO) || (seed == degen_msb(w));
  endfunction

  function automatic logic [SEED_MAX_W-1:0] sanitize_seed(input logic [SEED_MAX_W-1:0] seed,
                                                          input int unsigned w,
                                                          input logic [SEED_MAX_W-1:0] dflt);
    return is_degen_seed(seed, w) ? dflt : seed;
  endfunction

endpackage

// File: rtl/chaos_rr_pick.sv
// rtl/chaos_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module chaos_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req_vld[idx]) begin
        any_req   = 1'b1;
        grant[idx] = 1'b1;
        grant_id  = idx;
      end
    end
  end

endmodule

// File: rtl/chaos_seq_arbiter.sv
// rtl/chaos_seq_arbiter.sv - round-robin share of one logistic_seq engine among NUM_REQ seeders
// Optional per-requester/degenerate-seed counters under CHAOS_SEQ_ARBITER_STATS_EN.
module chaos_seq_arbiter
  import chaos_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAIN_INDEX   = GAIN_INDEX_DEF,
  parameter int CHAOS_OVLD_W = CHAOS_OVLD_W_DEF,
  parameter logic [GAIN_INDEX-1:0] DEFAULT_SEED = GAIN_INDEX'(DEFAULT_SEED_DEF),
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*GAIN_INDEX-1:0] req_x0,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [CHAOS_OVLD_W-1:0]       rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic [NUM_REQ-1:0]            rsp_vld,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic [GAIN_INDEX-1:0]         eng_x0,
  output logic                          eng_x0_vld,
  input  logic                          eng_x0_rdy,
  input  logic [CHAOS_OVLD_W-1:0]       eng_xout,
  input  logic                          eng_xout_vld,
  output logic                          eng_xout_rdy,
  output logic                          busy
`ifdef CHAOS_SEQ_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         served_cnt,
  output logic [15:0]                   degen_cnt
`endif
);

  arb_state_e state, state_nxt;

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       gnt_q;
  logic [GAIN_INDEX-1:0] seed_q;
  logic [GAIN_INDEX-1:0] seed_in;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_any;
  logic                  accept;
  logic                  result_take;
  logic                  rsp_done;

  chaos_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_vld  (req_vld),
    .rr_ptr   (rr_ptr),
    .grant    (pick_onehot),
    .grant_id (pick_id),
    .any_req  (pick_any)
  );

  always_comb begin
    seed_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) seed_in = req_x0[i*GAIN_INDEX +: GAIN_INDEX];
    end
  end

  assign accept      = (state == IDLE) && pick_any;
  assign result_take = (state == WAIT) && eng_xout_vld;
  assign rsp_done    = (state == RESP) && rsp_rdy[gnt_q];
  assign eng_x0      = seed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_rdy      = '0;
    eng_x0_vld   = 1'b0;
    eng_xout_rdy = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_rdy   = pick_onehot;
          state_nxt = SEND;
        end
      end
      SEND: begin
        eng_x0_vld = 1'b1;
        if (eng_x0_rdy) state_nxt = WAIT;
      end
      WAIT: begin
        eng_xout_rdy = 1'b1;
        if (eng_xout_vld) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_rdy[gnt_q]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      gnt_q    <= '0;
      seed_q   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_vld  <= '0;
    end else begin
      if (accept) begin
        seed_q <= GAIN_INDEX'(sanitize_seed(SEED_MAX_W'(seed_in), GAIN_INDEX,
                                            SEED_MAX_W'(DEFAULT_SEED)));
        gnt_q  <= pick_id;
      end
      if (result_take) begin
        rsp_data <= eng_xout;
        rsp_id   <= gnt_q;
        rsp_vld  <= NUM_REQ'(1) << gnt_q;
      end
      if (rsp_done) begin
        rsp_vld <= '0;
        rr_ptr  <= (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
      end
    end
  end

`ifdef CHAOS_SEQ_ARBITER_STATS_EN
  logic seed_degen;

  assign seed_degen = is_degen_seed(SEED_MAX_W'(seed_in), GAIN_INDEX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_cnt <= '0;
      degen_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_done && (gnt_q == ID_W'(i)) && (served_cnt[i*16 +: 16] != 16'hFFFF))
          served_cnt[i*16 +: 16] <= served_cnt[i*16 +: 16] + 16'd1;
      end
      if (accept && seed_degen && (degen_cnt != 16'hFFFF))
        degen_cnt <= degen_cnt + 16'd1;
    end
  end
`endif

endmodule
